// File: rtl/spi_instr_prefetch_if.sv
// Core-side and SPI-side signals of the instruction prefetcher, plus FSM/FIFO debug taps.
// Handshake: instr is meaningful only while instr_valid=1; instr_ack in a cycle with
// instr_valid=1 consumes the word at the clock edge, instr_ack with instr_valid=0 is ignored.
interface spi_instr_prefetch_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   pc_addr;
    logic          instr_ack;
    logic [15:0]   instr;
    logic          instr_valid;
    logic          spi_cs;
    logic          spi_sck;
    logic          spi_mosi;
    logic          spi_miso;
    logic [2:0]    dbg_state;
    logic [CW-1:0] dbg_count;

    modport slave (
        input  pc_addr, instr_ack, spi_miso,
        output instr, instr_valid, spi_cs, spi_sck, spi_mosi, dbg_state, dbg_count
    );

    modport master (
        output pc_addr, instr_ack, spi_miso,
        input  instr, instr_valid, spi_cs, spi_sck, spi_mosi, dbg_state, dbg_count
    );
endinterface

// File: rtl/spi_instr_prefetch.sv
// Sequential-burst SPI SRAM instruction prefetcher: streams tagged 16-bit words into a small
// FIFO, presents the word matching pc_addr, and restarts the burst when the PC branches away.
module spi_instr_prefetch #(
    parameter int DEPTH   = 4,
    parameter int CS_IDLE = 2
) (
    input  logic clk,
    input  logic rst,
    spi_instr_prefetch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(CS_IDLE) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] idle_cnt;
    logic [3:0]    bit_cnt;
    logic          sck, cs, mosi;
    logic [15:0]   fetch_ptr;
    logic [15:0]   tx_sr;
    logic [14:0]   rx_sr;
    logic [15:0]   tag_mem  [DEPTH];
    logic [15:0]   data_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_n;
    logic          empty, full, hit, pop, push, flush, start, fall, phase_end;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign hit   = !empty && (tag_mem[rd_ptr] == bus.pc_addr);
    assign pop   = bus.instr_ack && hit;
    // With the FIFO empty, fetch_ptr is the tag of the word currently being shifted in.
    assign flush = (!empty && !hit) ||
                   (empty && (state != S_IDLE) && (fetch_ptr != bus.pc_addr));
    assign fall  = sck;

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        phase_end = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE:  if (idle_cnt == IW'(CS_IDLE - 1)) begin
                         start   = 1'b1;
                         state_n = S_CMD;
                     end
            S_CMD:   if (fall && bit_cnt == 4'd7) begin
                         phase_end = 1'b1;
                         state_n   = S_ADDR;
                     end
            S_ADDR:  if (fall && bit_cnt == 4'd15) begin
                         phase_end = 1'b1;
                         state_n   = S_DATA;
                     end
            S_DATA:  if (fall && bit_cnt == 4'd15) begin
                         phase_end = 1'b1;
                         push      = !flush;
                     end
            S_PAUSE: if (!full) state_n = S_DATA;
            default: state_n = S_IDLE;
        endcase
        count_n = count + CW'(push) - CW'(pop);
        if (state == S_DATA && push && count_n == CW'(DEPTH)) state_n = S_PAUSE;
        if (flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            idle_cnt  <= '0;
            bit_cnt   <= 4'd0;
            fetch_ptr <= 16'h0000;
            tx_sr     <= 16'h0000;
            rx_sr     <= 15'h0000;
        end else if (flush) begin
            cs       <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            idle_cnt <= '0;
            bit_cnt  <= 4'd0;
        end else begin
            if (state == S_IDLE) idle_cnt <= start ? '0 : idle_cnt + 1'b1;
            if (start) begin
                // First command bit (0) goes out with CS; remaining bits of 0x03 queue behind it.
                cs        <= 1'b0;
                mosi      <= 1'b0;
                tx_sr     <= {7'b000_0011, 9'b0};
                fetch_ptr <= bus.pc_addr;
                bit_cnt   <= 4'd0;
            end
            if (state inside {S_CMD, S_ADDR, S_DATA}) begin
                sck <= ~sck;
                if (fall) begin
                    bit_cnt <= (state == S_CMD && phase_end) ? 4'd0 : bit_cnt + 4'd1;
                    rx_sr   <= {rx_sr[13:0], bus.spi_miso};
                    if (state == S_CMD && phase_end) begin
                        mosi  <= fetch_ptr[14];
                        tx_sr <= {fetch_ptr[13:0], 2'b00};
                    end else if (state == S_ADDR && phase_end) begin
                        mosi <= 1'b0;
                    end else begin
                        mosi  <= tx_sr[15];
                        tx_sr <= {tx_sr[14:0], 1'b0};
                    end
                    if (push) fetch_ptr <= fetch_ptr + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i]  <= 16'h0000;
                data_mem[i] <= 16'h0000;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr]  <= fetch_ptr;
                data_mem[wr_ptr] <= {rx_sr, bus.spi_miso};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
        end
    end

    assign bus.spi_cs      = cs;
    assign bus.spi_sck     = sck;
    assign bus.spi_mosi    = mosi;
    assign bus.instr       = data_mem[rd_ptr];
    assign bus.instr_valid = hit;
    assign bus.dbg_state   = state;
    assign bus.dbg_count   = count;
endmodule

// File: tb/tb_spi_instr_prefetch.sv
// Bench for spi_instr_prefetch: behavioural SPI SRAM with an external MISO synchronizer,
// a table of fetch vectors plus hand-written reset, FIFO-full and streaming sequences.
`timescale 1ns/1ps
module tb_spi_instr_prefetch;
    logic clk;
    logic rst;

    spi_instr_prefetch_if #(.DEPTH(4)) bus ();

    spi_instr_prefetch #(.DEPTH(4), .CS_IDLE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // SPI SRAM model: bytes default to addr[7:0]+0x11, bytes 0..3 hold 12 34 AB CD
    logic [7:0]  mem [0:65535];
    int          s_cnt;
    int          s_bursts;
    int          s_d;
    logic [23:0] s_in;
    logic [7:0]  s_cmd;
    logic [15:0] s_addr;
    logic [15:0] s_a;
    logic        miso_raw;
    logic        miso_sync;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a + 8'h11);
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        mem[2] = 8'hAB;
        mem[3] = 8'hCD;
        miso_raw = 1'b0;
    end

    always @(posedge bus.spi_sck or posedge bus.spi_cs) begin
        if (bus.spi_cs) begin
            s_cnt = 0;
        end else begin
            if (s_cnt < 24) s_in = {s_in[22:0], bus.spi_mosi};
            s_cnt = s_cnt + 1;
            if (s_cnt == 24) begin
                s_cmd    = s_in[23:16];
                s_addr   = s_in[15:0];
                s_bursts = s_bursts + 1;
            end
        end
    end

    always @(negedge bus.spi_sck) begin
        if (!bus.spi_cs && s_cnt >= 24) begin
            s_d      = s_cnt - 24;
            s_a      = s_addr + 16'(s_d / 8);
            miso_raw = mem[s_a][7 - (s_d % 8)];
        end
    end

    always @(posedge clk) miso_sync <= miso_raw;
    assign bus.spi_miso = miso_sync;

    function automatic logic [15:0] model_word(input logic [15:0] tag);
        logic [15:0] b;
        b = {tag[14:0], 1'b0};
        return {mem[b], mem[b + 16'd1]};
    endfunction

    // bus monitors
    int      cs_rises;
    int      sck_rises;
    longint  t_rise;
    longint  t_fall;
    longint  min_cs_hi;
    int      max_cnt;
    logic    mon_clear;

    initial begin
        min_cs_hi = 64'd1000000;
        t_rise    = 0;
    end

    always @(posedge bus.spi_cs) begin
        cs_rises = cs_rises + 1;
        t_rise   = $time;
    end

    always @(negedge bus.spi_cs) begin
        t_fall = $time;
        if (t_fall - t_rise < min_cs_hi) min_cs_hi = t_fall - t_rise;
    end

    always @(posedge bus.spi_sck) sck_rises = sck_rises + 1;

    always @(negedge clk) begin
        if (mon_clear) max_cnt = 0;
        else if (int'(bus.dbg_count) > max_cnt) max_cnt = int'(bus.dbg_count);
    end

    // scoreboard counters and driver tasks
    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.instr_ack = 1'b0;
        bus.pc_addr   = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_state(input string name, input logic [2:0] st);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.dbg_state == st) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_count(input string name, input int n);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (int'(bus.dbg_count) >= n) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic consume();
        bus.instr_ack = 1'b1;
        @(negedge clk);
        bus.instr_ack = 1'b0;
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] exp_instr;
        int          fill_to;
        int          exp_restarts;
        bit          chk_addr;
        logic [15:0] exp_addr;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int     r0, b0, k0;
    longint lat;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        mon_clear     = 1'b1;
        rst           = 1'b0;
        bus.instr_ack = 1'b0;
        bus.pc_addr   = 16'h0000;

        vecs[0] = '{16'h0000, 16'h1234, 0, 0, 1'b1, 16'h0000};
        vecs[1] = '{16'h0001, 16'hABCD, 0, 0, 1'b0, 16'h0000};
        vecs[2] = '{16'h0002, 16'h1516, 0, 0, 1'b0, 16'h0000};
        vecs[3] = '{16'h0003, 16'h1718, 4, 0, 1'b0, 16'h0000};
        vecs[4] = '{16'h0040, 16'h9192, 0, 1, 1'b1, 16'h0080};
        vecs[5] = '{16'h0041, 16'h9394, 0, 0, 1'b0, 16'h0000};
        vecs[6] = '{16'h7FFF, 16'h0F10, 0, 1, 1'b1, 16'hFFFE};
        vecs[7] = '{16'h8000, 16'h1234, 0, 0, 1'b0, 16'h0000};
        vecs[8] = '{16'h8001, 16'hABCD, 0, 0, 1'b0, 16'h0000};

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(bus.spi_cs), 32'd1);
        check("rst_sck", 32'(bus.spi_sck), 32'd0);
        check("rst_mosi", 32'(bus.spi_mosi), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        check("rst_count", 32'(bus.dbg_count), 32'd0);
        rst = 1'b0;

        // table: sequential fetch, FIFO pre-fill, branch flush, address wrap
        for (int i = 0; i < NV; i++) begin
            r0          = cs_rises;
            bus.pc_addr = vecs[i].pc;
            if (vecs[i].fill_to > 0) wait_count($sformatf("tbl%0d_fill", i), vecs[i].fill_to);
            wait_valid($sformatf("tbl%0d_valid", i));
            check($sformatf("tbl%0d_instr", i), 32'(bus.instr), 32'(vecs[i].exp_instr));
            check($sformatf("tbl%0d_restarts", i), 32'(cs_rises - r0), 32'(vecs[i].exp_restarts));
            if (vecs[i].chk_addr) begin
                check($sformatf("tbl%0d_cmd", i), 32'(s_cmd), 32'h03);
                check($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(vecs[i].exp_addr));
            end
            consume();
        end
        check("cs_high_min", 32'(min_cs_hi >= 20), 32'd1);

        // reset during the address phase
        do_reset();
        wait_state("mid_reach_addr", 3'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_cs", 32'(bus.spi_cs), 32'd1);
        check("mid_rst_sck", 32'(bus.spi_sck), 32'd0);
        check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        b0 = s_bursts;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_valid("mid_valid");
        check("mid_bursts", 32'(s_bursts - b0), 32'd1);
        check("mid_cmd", 32'(s_cmd), 32'h03);
        check("mid_addr", 32'(s_addr), 32'h0000);
        check("mid_instr", 32'(bus.instr), 32'h1234);

        // FIFO full: no acks until the prefetcher pauses, then exactly one refill
        do_reset();
        wait_valid("full_first_valid");
        lat = ($time - t_fall) / 10;
        check("full_latency", 32'(lat >= 80 && lat <= 82), 32'd1);
        wait_state("full_pause", 3'd4);
        check("full_count", 32'(bus.dbg_count), 32'd4);
        check("full_cs_low", 32'(bus.spi_cs), 32'd0);
        check("full_sck_low", 32'(bus.spi_sck), 32'd0);
        k0 = sck_rises;
        repeat (40) @(negedge clk);
        check("full_sck_stopped", 32'(sck_rises - k0), 32'd0);
        r0 = cs_rises;
        k0 = sck_rises;
        consume();
        bus.pc_addr = 16'h0001;
        repeat (100) @(negedge clk);
        check("full_one_word", 32'(sck_rises - k0), 32'd16);
        check("full_repause", 32'(bus.dbg_state), 32'd4);
        check("full_recount", 32'(bus.dbg_count), 32'd4);
        check("full_next_instr", 32'(bus.instr_valid ? bus.instr : 16'h0000), 32'hABCD);
        check("full_no_restart", 32'(cs_rises - r0), 32'd0);

        // streaming with an ack as each word lands
        do_reset();
        mon_clear = 1'b1;
        repeat (2) @(negedge clk);
        mon_clear = 1'b0;
        r0 = cs_rises;
        for (int i = 0; i < 16; i++) begin
            bus.pc_addr = 16'(i);
            wait_valid($sformatf("stream%0d_valid", i));
            check($sformatf("stream%0d_instr", i), 32'(bus.instr), 32'(model_word(16'(i))));
            consume();
        end
        check("stream_max_count", 32'(max_cnt <= 1), 32'd1);
        check("stream_no_restart", 32'(cs_rises - r0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_instr_prefetch.md
Name: spi_instr_prefetch

Overview:
- Instruction prefetch stage placed upstream of the CPU core; replaces the single-fetch SPI program memory path.
- Streams sequential 16-bit instructions from an external SPI SRAM using the READ (0x03) sequential-burst command.
- Buffers the words in a small tagged FIFO and presents the word matching the core's current PC.
- When the PC leaves the sequential stream (branch), flushes the FIFO and restarts the burst at the new address.

Parameters:
- DEPTH, 4, FIFO entries (16-bit instruction plus 16-bit word-address tag); power of two, ≥2.
- CS_IDLE, 2, minimum clk cycles spi_cs stays high between bursts.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pc_addr  input  16  word address the core wants to execute
- instr_ack  input  1  core consumed the presented instruction this cycle
- instr  output  16  instruction at pc_addr; valid only when instr_valid=1
- instr_valid  output  1  FIFO head tag equals pc_addr
- spi_cs  output  1  SRAM chip select, active low
- spi_sck  output  1  SPI clock, mode 0, clk/2
- spi_mosi  output  1  command/address out, MSB first
- spi_miso  input  1  SRAM data; already registered by one synchronizer flop outside this block

Behaviour:
- Reset values: spi_cs=1, spi_sck=0, spi_mosi=0, instr_valid=0, instr=0, FIFO empty, FSM in IDLE. rst also aborts any burst mid-transfer: CS rises asynchronously.
- Byte address sent = {pc[14:0],1'b0}, 16 bits. Instruction is big-endian: first byte received becomes instr[15:8].
- SCK: toggles every clk while shifting; mode 0.
  - MOSI changes on the cycle SCK goes low.
  - MISO is sampled on the clk edge where SCK goes 1→0. This compensates for the external synchronizer delay.
- FSM states:
  - IDLE: waits CS_IDLE cycles with CS high, then loads fetch_ptr with the restart address.
  - CMD: 8 bits, 0x03.
  - ADDR: 16 bits.
  - DATA: 16 bits per word. When a word completes, push {tag=fetch_ptr, data} and increment fetch_ptr (wraps 0xFFFF→0x0000).
  - PAUSE: entered when the FIFO is full at a word boundary. CS stays low and SCK stays low. Returns to DATA the cycle after the FIFO has space.
- Presentation:
  - instr_valid = FIFO non-empty AND head tag == pc_addr. Combinational from registered FIFO head.
  - instr = head data.
  - instr_ack while instr_valid=1 pops the head.
  - instr_ack while instr_valid=0 is ignored.
- Mismatch/flush:
  - Trigger: instr_valid=0, FIFO non-empty, and head tag != pc_addr. Also triggered by FIFO empty, a burst active, and the burst's next expected tag (fetch_ptr minus in-flight) != pc_addr.
  - Action: clear the FIFO, drive CS high, go to IDLE, and restart at pc_addr.
  - A partial word in flight is discarded.
- Simultaneous push and pop in one cycle: both occur; count is unchanged.
- A push completing in the same cycle as a flush is dropped.
- Start-up: after reset release, the FSM leaves IDLE and fetches from pc_addr (0x0000 at core reset).
- Latency from restart (CS falling) to first instr_valid: 24 SCK periods for command+address plus 16 for data = 80 clk, plus ≤2 clk for push/compare.
- Steady-state throughput: one instruction per 32 clk while the FIFO is not full.

Test Plan:
- Reset mid-burst: assert rst during ADDR phase → spi_cs=1, spi_sck=0, instr_valid=0 immediately. After release, a new burst starts with MOSI bits 0x03, 0x0000.
- Sequential fetch: SRAM model holds 0x1234 at byte 0, 0xABCD at byte 2; pc_addr=0 → instr=0x1234, valid within 82 clk of CS fall. Ack, pc_addr=1 → instr=0xABCD with no CS toggle.
- FIFO full: core never acks with pc_addr=0 → after 4 words, SCK stops with CS low (PAUSE). Ack once → exactly one more word is fetched.
- Branch flush: after 3 words are buffered, set pc_addr=0x0040 → CS high ≥2 cycles, MOSI sends 0x03, 0x0080, and the first valid instr is the model word at byte 0x80.
- Push/pop same cycle: keep acking every word as it arrives → FIFO count never exceeds 1 and no word is lost over 16 instructions.
- Address wrap: pc_addr=0x7FFF → address 0xFFFE sent; the next tag is 0x8000, whose byte address wraps to the model's byte 0x0000. Data match is required.
